// File: rtl/pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pll_reset_ctrl
//  Brief    : Sequences the PLL on the free-running reference clock. It holds
//             the PLL in reset, waits for lock, and confirms that lock is
//             stable before it releases the active-low system reset. It
//             retries on lock timeout, goes sticky-fail after too many
//             retries, and re-sequences on loss of lock.
//  Options  : LOCK_LOSS_CNT_EN - adds the saturating 8-bit loss-of-lock
//             counter and its loss_cnt_o port.
//  Revision : 1.0  initial release
// ============================================================================
module pll_reset_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 7,
   parameter int CNT_W         = 16
) (
   input  logic       refclk_i,
   input  logic       rst_n_i,
   input  logic       locked_i,
   input  logic       soft_rst_i,
   output logic       pll_rst_o,
   output logic       sys_rst_n_o,
   output logic       ready_o,
   output logic [1:0] state_o,
   output logic [2:0] retry_cnt_o,
   output logic       fail_o
`ifdef LOCK_LOSS_CNT_EN
   ,
   output logic [7:0] loss_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_RST    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STABLE = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   // Terminal counts of the shared cycle counter, one per timed state
   localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);
   localparam logic [2:0]       C_MAX_RETRY   = 3'(MAX_RETRY);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       retry_q;
   logic             fail_q;
   logic             pll_rst_q;
   logic             sys_rst_n_q;
   logic             ready_q;
   logic             lock_meta_q;
   logic             locked_s_q;
`ifdef LOCK_LOSS_CNT_EN
   logic [7:0]       loss_q;
`endif

   // Two-flop synchronizer bringing the asynchronous PLL lock into refclk
   always_ff @(posedge refclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_meta_q <= 1'b0;
         locked_s_q  <= 1'b0;
      end else begin
         lock_meta_q <= locked_i;
         locked_s_q  <= lock_meta_q;
      end
   end

   // Sequencer FSM. Every output is updated on the same edge as the state
   // change that implies it, so the output flops always agree with state_q.
   always_ff @(posedge refclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         fail_q      <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
      end else if (soft_rst_i) begin
         // Re-sequence request overrides everything, including a lock loss
         state_q     <= ST_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         fail_q      <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_RST: begin
               pll_rst_q   <= 1'b1;
               sys_rst_n_q <= 1'b0;
               ready_q     <= 1'b0;
               if (fail_q) begin
                  // Parked until soft reset; counter held so it cannot wrap
                  cnt_q <= '0;
               end else if (cnt_q == C_RST_LAST) begin
                  state_q   <= ST_WAIT;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + C_CNT_ONE;
               end
            end

            ST_WAIT: begin
               if (locked_s_q) begin
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
               end else if (cnt_q == C_TIMEOUT_LAST) begin
                  // Out of retries: go sticky-fail, retry count left as is
                  if (retry_q == C_MAX_RETRY) begin
                     fail_q <= 1'b1;
                  end else begin
                     retry_q <= retry_q + 3'd1;
                  end
                  state_q   <= ST_RST;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + C_CNT_ONE;
               end
            end

            ST_STABLE: begin
               if (!locked_s_q) begin
                  // Lock glitch: restart the timeout, not a counted retry
                  state_q <= ST_WAIT;
                  cnt_q   <= '0;
               end else if (cnt_q == C_STABLE_LAST) begin
                  state_q     <= ST_RUN;
                  cnt_q       <= '0;
                  retry_q     <= '0;
                  sys_rst_n_q <= 1'b1;
                  ready_q     <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + C_CNT_ONE;
               end
            end

            ST_RUN: begin
               if (!locked_s_q) begin
                  state_q     <= ST_RST;
                  cnt_q       <= '0;
                  pll_rst_q   <= 1'b1;
                  sys_rst_n_q <= 1'b0;
                  ready_q     <= 1'b0;
               end
            end

            default: begin
               state_q     <= ST_RST;
               cnt_q       <= '0;
               pll_rst_q   <= 1'b1;
               sys_rst_n_q <= 1'b0;
               ready_q     <= 1'b0;
            end
         endcase
      end
   end

`ifdef LOCK_LOSS_CNT_EN
   // Saturating count of RUN->RST drops caused by lock loss; soft reset
   // takes priority over the drop and does not clear the count
   always_ff @(posedge refclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         loss_q <= '0;
      end else if (!soft_rst_i && (state_q == ST_RUN) && !locked_s_q
                   && (loss_q != 8'hFF)) begin
         loss_q <= loss_q + 8'd1;
      end
   end

   assign loss_cnt_o = loss_q;
`endif

   assign pll_rst_o   = pll_rst_q;
   assign sys_rst_n_o = sys_rst_n_q;
   assign ready_o     = ready_q;
   assign state_o     = state_q;
   assign retry_cnt_o = retry_q;
   assign fail_o      = fail_q;

endmodule
`default_nettype wire
